// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus timer slice.
// Holds the CTRL bit positions, the MODE encoding and the register offsets
// seen on Addr (PrAddr[3:2]). It also holds the FSM state type and a small
// helper that decodes MODE.
package bus_timer_pkg;

  // CTRL register layout; bits [31:4] always read as zero and drop writes
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam logic [31:0] CTRL_WRITE_MASK = 32'h0000_000F;

  // MODE encoding: only 01 reloads, every other value (including the
  // reserved 1x codes) runs as one-shot
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  // Word offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int TIMER_STATE_SIZE = 2;

  typedef enum logic [TIMER_STATE_SIZE-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_AUTO_RELOAD);
  endfunction

endpackage

// File: rtl/bus_timer_be_merge.sv
// Byte-enable merge for software-written registers.
// Ports:
//   old_word : current register contents
//   wd       : bus write data
//   be       : byte enables, bit i selects wd byte i
//   merged   : old_word with the enabled bytes replaced by wd
module bus_timer_be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wd[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Programmable down-counting timer on the processor-side bus.
// Ports:
//   Clock : system clock, all state changes on the rising edge
//   Reset : synchronous active-high reset
//   Sel   : decoded select from the bus bridge
//   Addr  : word offset (PrAddr[3:2]) - 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   WE    : write strobe, qualified by Sel
//   BE    : byte enables for writes
//   WD    : write data
//   RD    : combinational read data for the addressed register
//   IRQ   : interrupt request, IM & PEND
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  timer_state_e state_q, state_d;
  logic [31:0]  ctrl_q, ctrl_d;
  logic [31:0]  preset_q, preset_d;
  logic [31:0]  count_q, count_d;
  logic         pend_q, pend_d;
  logic         pend_set;

  logic         ctrl_wr, preset_wr;
  logic [31:0]  ctrl_merged, preset_merged;
  logic         ctrl_en, ctrl_im;
  logic [1:0]   ctrl_mode;

  assign ctrl_wr   = Sel & WE & (Addr == REG_CTRL);
  assign preset_wr = Sel & WE & (Addr == REG_PRESET);

  assign ctrl_en   = ctrl_q[CTRL_EN_BIT];
  assign ctrl_im   = ctrl_q[CTRL_IM_BIT];
  assign ctrl_mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  bus_timer_be_merge u_ctrl_merge (
    .old_word (ctrl_q),
    .wd       (WD),
    .be       (BE),
    .merged   (ctrl_merged)
  );

  bus_timer_be_merge u_preset_merge (
    .old_word (preset_q),
    .wd       (WD),
    .be       (BE),
    .merged   (preset_merged)
  );

  // Next-state logic. The FSM updates run first and the bus writes are
  // applied afterwards, so a CTRL write in the INT cycle overrides the
  // hardware clear of EN. A PRESET write only changes PRESET; COUNT picks
  // it up at the next LOAD. A terminal count that coincides with a clearing
  // write keeps PEND set so that the interrupt is not lost.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    pend_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d  = ST_INT;
          pend_set = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (is_auto_reload(ctrl_mode)) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrl_wr) begin
      ctrl_d = ctrl_merged & CTRL_WRITE_MASK;
    end
    if (preset_wr) begin
      preset_d = preset_merged;
    end

    if (pend_set) begin
      pend_d = 1'b1;
    end else if (ctrl_wr || preset_wr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 32'd0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    RD = 32'd0;
    case (Addr)
      REG_CTRL:   RD = ctrl_q;
      REG_PRESET: RD = preset_q;
      REG_COUNT:  RD = count_q;
      REG_RSVD:   RD = 32'd0;
      default:    RD = 32'd0;
    endcase
  end

  assign IRQ = ctrl_im & pend_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer.
// Stimulus pushes expected RD/IRQ values into a scoreboard queue; a monitor
// on the falling edge pops one entry whenever a probe is armed and compares.
// Expected timer behaviour comes from a period-level timeline: first LOAD
// one cycle after the enabling write, COUNT=N in the next cycle, one
// decrement per cycle, INT two cycles after COUNT reaches its load point
// plus N, and in auto-reload a new LOAD right after each INT.
module tb_bus_timer;

  localparam logic [31:0] RESET_PRESET_VAL = 32'hDEAD_0004;

  logic        Clock;
  logic        Reset;
  logic        Sel;
  logic [1:0]  Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  bus_timer #(.RESET_PRESET(RESET_PRESET_VAL)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Sel   (Sel),
    .Addr  (Addr),
    .WE    (WE),
    .BE    (BE),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          chk_irq;
    bit          exp_irq;
  } expect_t;

  expect_t     sb[$];
  bit          probe_req;
  int          check_count;
  int          pass_count;
  logic [31:0] model_preset;
  logic [3:0]  model_ctrl;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one scoreboard entry against the DUT outputs
  task automatic checkOutput(input expect_t e);
    if (e.chk_rd) begin
      check_count++;
      if (RD === e.exp_rd) pass_count++;
      else $display("[TB] FAIL %s: RD got %h, required %h", e.name, RD, e.exp_rd);
    end
    if (e.chk_irq) begin
      check_count++;
      if (IRQ === e.exp_irq) pass_count++;
      else $display("[TB] FAIL %s: IRQ got %b, required %b", e.name, IRQ, e.exp_irq);
    end
  endtask

  // Monitor: samples away from the active edge whenever a probe is armed
  always @(negedge Clock) begin
    if (probe_req) begin
      if (sb.size() == 0) begin
        check_count++;
        $display("[TB] FAIL scoreboard_underflow: got probe with empty queue, required a queued entry");
      end else begin
        checkOutput(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "[TB] time limit reached");
  end

  // Drive the bus inputs for the current cycle
  task automatic applyStimulus(input logic sel, input logic we, input logic [1:0] addr,
                               input logic [31:0] wd, input logic [3:0] be);
    Sel  = sel;
    WE   = we;
    Addr = addr;
    WD   = wd;
    BE   = be;
  endtask

  task automatic expect_out(input string name, input bit chk_rd, input logic [31:0] exp_rd,
                            input bit chk_irq, input bit exp_irq);
    expect_t e;
    e.name = name; e.chk_rd = chk_rd; e.exp_rd = exp_rd;
    e.chk_irq = chk_irq; e.exp_irq = exp_irq;
    sb.push_back(e);
    probe_req = 1'b1;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    probe_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp_rd,
                            input bit chk_irq, input bit exp_irq);
    applyStimulus(1'b1, 1'b0, addr, 32'd0, 4'd0);
    expect_out(name, 1'b1, exp_rd, chk_irq, exp_irq);
    step();
  endtask

  task automatic write_reg(input string name, input logic [1:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input bit chk_irq, input bit exp_irq);
    applyStimulus(1'b1, 1'b1, addr, data, be);
    if (chk_irq) expect_out(name, 1'b0, 32'd0, 1'b1, exp_irq);
    step();
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Expected PEND/COUNT k cycles after the enabling write edge
  function automatic void timeline(input int k, input int n_first, input int n_rest, input bit reload,
                                   output bit pend, output bit known, output logic [31:0] cnt);
    int load_k;
    int n;
    int int_k;
    load_k = 1; n = n_first; pend = 1'b0; known = 1'b0; cnt = 32'd0;
    if (k < 1) return;
    for (int p = 0; p < 10000; p++) begin
      if (k == load_k) begin
        known = (load_k > 1);
        return;
      end
      int_k = load_k + n + 2;
      if (k < int_k) begin
        known = 1'b1;
        cnt = 32'(n - (k - load_k - 1));
        return;
      end
      known = 1'b1; cnt = 32'd0; pend = 1'b1;
      if (!reload || k == int_k) return;
      pend = 1'b0;
      load_k = int_k + 1;
      n = n_rest;
    end
  endfunction

  task automatic run_window(input string tag, input int k0, input int k1, input int n_first,
                            input int n_rest, input bit reload, input bit im, input logic [3:0] ctrl_val);
    bit          pend;
    bit          known;
    logic [31:0] cnt;
    logic [31:0] ctrl_exp;
    for (int k = k0; k <= k1; k++) begin
      timeline(k, n_first, n_rest, reload, pend, known, cnt);
      ctrl_exp = {28'd0, ctrl_val};
      if (!reload && k >= n_first + 4) ctrl_exp[0] = 1'b0;
      if (known && (k % 2 == 1))
        read_check($sformatf("%s_count_k%0d", tag, k), 2'd2, cnt, 1'b1, im & pend);
      else
        read_check($sformatf("%s_ctrl_k%0d", tag, k), 2'd0, ctrl_exp, 1'b1, im & pend);
    end
  endtask

  task automatic oneshot_run(input string tag, input int n, input bit im, input logic [1:0] mode);
    logic [3:0] c;
    c = {im, mode, 1'b1};
    write_reg({tag, "_wr_preset"}, 2'd1, 32'(n), 4'hF, 1'b1, 1'b0);
    read_check({tag, "_preset"}, 2'd1, 32'(n), 1'b1, 1'b0);
    write_reg({tag, "_wr_ctrl"}, 2'd0, {28'd0, c}, 4'hF, 1'b1, 1'b0);
    run_window(tag, 0, n + 7, n, n, 1'b0, im, c);
    write_reg({tag, "_clr_wr"}, 2'd0, 32'd0, 4'hF, 1'b1, im);
    read_check({tag, "_after_clr"}, 2'd0, 32'd0, 1'b1, 1'b0);
    model_preset = 32'(n);
  endtask

  task automatic autoreload_run(input string tag, input int n_first, input int n_rest, input bit im,
                                input int change_k);
    logic [3:0]  c;
    bit          pend;
    bit          known;
    logic [31:0] cnt;
    int          stop_k;
    c = {im, 2'b01, 1'b1};
    stop_k = (n_first + 3) + (n_first == n_rest ? 3 * (n_rest + 3) : 2 * (n_rest + 3)) + 1;
    write_reg({tag, "_wr_preset"}, 2'd1, 32'(n_first), 4'hF, 1'b1, 1'b0);
    write_reg({tag, "_wr_ctrl"}, 2'd0, {28'd0, c}, 4'hF, 1'b1, 1'b0);
    if (change_k > 0) begin
      run_window(tag, 0, change_k - 1, n_first, n_rest, 1'b1, im, c);
      timeline(change_k, n_first, n_rest, 1'b1, pend, known, cnt);
      write_reg({tag, "_wr_new_preset"}, 2'd1, 32'(n_rest), 4'hF, 1'b1, im & pend);
      run_window(tag, change_k + 1, stop_k - 1, n_first, n_rest, 1'b1, im, c);
    end else begin
      run_window(tag, 0, stop_k - 1, n_first, n_rest, 1'b1, im, c);
    end
    timeline(stop_k, n_first, n_rest, 1'b1, pend, known, cnt);
    write_reg({tag, "_stop"}, 2'd0, {28'd0, c[3:1], 1'b0}, 4'hF, 1'b1, im & pend);
    timeline(stop_k + 1, n_first, n_rest, 1'b1, pend, known, cnt);
    repeat (4) step();
    read_check({tag, "_ctrl_stopped"}, 2'd0, {28'd0, c[3:1], 1'b0}, 1'b1, 1'b0);
    read_check({tag, "_count_held"}, 2'd2, cnt, 1'b1, 1'b0);
    read_check({tag, "_preset_final"}, 2'd1, 32'(n_rest), 1'b1, 1'b0);
    write_reg({tag, "_ctrl_zero"}, 2'd0, 32'd0, 4'hF, 1'b0, 1'b0);
    model_preset = 32'(n_rest);
  endtask

  initial begin
    logic [31:0] data;
    logic [3:0]  be;
    int          n;
    logic [1:0]  mode;

    probe_req = 1'b0;
    check_count = 0;
    pass_count = 0;
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
    step();
    step();

    // Reset state
    read_check("rst_ctrl", 2'd0, 32'd0, 1'b1, 1'b0);
    read_check("rst_preset", 2'd1, RESET_PRESET_VAL, 1'b1, 1'b0);
    read_check("rst_count", 2'd2, 32'd0, 1'b1, 1'b0);
    read_check("rst_rsvd", 2'd3, 32'd0, 1'b1, 1'b0);
    Reset = 1'b0;
    step();
    model_preset = RESET_PRESET_VAL;
    model_ctrl = 4'd0;

    // Byte-granular writes
    write_reg("be_full", 2'd1, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
    read_check("be_full_rd", 2'd1, 32'h1122_3344, 1'b0, 1'b0);
    write_reg("be_0101", 2'd1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
    read_check("be_0101_rd", 2'd1, 32'h11BB_33DD, 1'b0, 1'b0);
    model_preset = 32'h11BB_33DD;
    write_reg("be_none", 2'd1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0);
    read_check("be_none_rd", 2'd1, model_preset, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      data = $urandom;
      be = 4'($urandom_range(0, 15));
      write_reg("be_rand", 2'd1, data, be, 1'b0, 1'b0);
      model_preset = merge_bytes(model_preset, data, be);
      read_check($sformatf("be_rand_rd%0d", i), 2'd1, model_preset, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      data = $urandom & 32'hFFFF_FFFE;
      be = 4'($urandom_range(0, 15));
      write_reg("ctrl_rand", 2'd0, data, be, 1'b0, 1'b0);
      if (be[0]) model_ctrl = data[3:0];
      read_check($sformatf("ctrl_rand_rd%0d", i), 2'd0, {28'd0, model_ctrl}, 1'b0, 1'b0);
    end
    write_reg("ctrl_zero", 2'd0, 32'd0, 4'hF, 1'b0, 1'b0);
    write_reg("count_wr", 2'd2, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    read_check("count_ro", 2'd2, 32'd0, 1'b1, 1'b0);
    write_reg("rsvd_wr", 2'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    read_check("rsvd_ro", 2'd3, 32'd0, 1'b1, 1'b0);

    // One-shot: directed then randomized
    oneshot_run("os5", 5, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      n = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0: mode = 2'b00;
        1: mode = 2'b10;
        default: mode = 2'b11;
      endcase
      oneshot_run($sformatf("osr%0d", i), n, 1'($urandom_range(0, 1)), mode);
    end

    // Auto-reload: directed with and without IM, then randomized
    autoreload_run("ar3", 3, 3, 1'b1, 0);
    autoreload_run("ar3m", 3, 3, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      n = $urandom_range(0, 6);
      autoreload_run($sformatf("arr%0d", i), n, n, 1'($urandom_range(0, 1)), 0);
    end

    // PRESET rewrite during CNT: current period from 10, later ones from 2
    autoreload_run("midp", 10, 2, 1'b1, 4);

    // CTRL write landing in the one-shot INT cycle
    n = $urandom_range(0, 5);
    write_reg("sim_wr_preset", 2'd1, 32'(n), 4'hF, 1'b1, 1'b0);
    write_reg("sim_wr_ctrl", 2'd0, 32'h9, 4'hF, 1'b1, 1'b0);
    run_window("sim", 0, n + 2, n, n, 1'b0, 1'b1, 4'h9);
    write_reg("sim_int_wr", 2'd0, 32'h9, 4'hF, 1'b1, 1'b1);
    run_window("simre", 0, n + 5, n, n, 1'b0, 1'b1, 4'h9);
    write_reg("sim_clr", 2'd0, 32'd0, 4'hF, 1'b1, 1'b1);
    read_check("sim_after_clr", 2'd0, 32'd0, 1'b1, 1'b0);

    // Reset mid-count with COUNT=7
    write_reg("rmc_wr_preset", 2'd1, 32'd10, 4'hF, 1'b0, 1'b0);
    write_reg("rmc_wr_ctrl", 2'd0, 32'h9, 4'hF, 1'b0, 1'b0);
    run_window("rmc", 0, 4, 10, 10, 1'b0, 1'b1, 4'h9);
    read_check("rmc_count7", 2'd2, 32'd7, 1'b1, 1'b0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    read_check("rmc_count0", 2'd2, 32'd0, 1'b1, 1'b0);
    read_check("rmc_ctrl0", 2'd0, 32'd0, 1'b1, 1'b0);
    read_check("rmc_preset", 2'd1, RESET_PRESET_VAL, 1'b1, 1'b0);

    // Reset while an interrupt is pending
    write_reg("rint_wr_preset", 2'd1, 32'd0, 4'hF, 1'b0, 1'b0);
    write_reg("rint_wr_ctrl", 2'd0, 32'h9, 4'hF, 1'b0, 1'b0);
    run_window("rint", 0, 4, 0, 0, 1'b0, 1'b1, 4'h9);
    Reset = 1'b1;
    expect_out("rint_irq_before", 1'b0, 32'd0, 1'b1, 1'b1);
    step();
    Reset = 1'b0;
    read_check("rint_irq_after", 2'd0, 32'd0, 1'b1, 1'b0);

    step();
    step();
    if (sb.size() != 0) begin
      check_count++;
      $display("[TB] FAIL scoreboard_leftover: got %0d unchecked entries, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
